modmult_interleaved: RTL
========================

MODMULT_INTERLEAVED -- requirements
Module: modmult_interleaved

Interface
REQ-001 Parameter NLEN, default 1024, modulus magnitude width; N is NLEN+1 bits signed.
REQ-002 Parameter TAG, default 2, extra headroom bits on operand/result ports.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; also the initiator's restart pulse.
REQ-005 in1  input  NLEN+TAG+1  signed multiplicand; precondition 0 <= in1 < N.
REQ-006 in2  input  NLEN+TAG+1  signed multiplier; only bits [NLEN:0] are used, as unsigned.
REQ-007 N  input  NLEN+1  signed modulus; precondition N > 0.
REQ-008 in_ready  input  1  level request from initiator; operands stable while high.
REQ-009 out  output  NLEN+TAG+1  signed result in1*in2 mod N, zero-extended.
REQ-010 out_ready  output  1  result valid, held high until reset or in_ready low.

Function
REQ-011 States SHALL be IDLE, RUN, DONE; encoding is free.
REQ-012 IDLE with in_ready=1 at a posedge SHALL capture in1, in2[NLEN:0], N, set P=0, bit counter=NLEN, and go to RUN.
REQ-013 IDLE with in_ready=0 SHALL hold all registers; out keeps its last value; out_ready=0.
REQ-014 Each RUN cycle SHALL compute T = 2P + (in2[counter] ? in1 : 0), then P <= T-2N if T>=2N, else T-N if T>=N, else T.
REQ-015 Internal accumulator width SHALL be NLEN+3 bits unsigned so 2P+in1 < 3N never overflows.
REQ-016 RUN SHALL last exactly NLEN+1 cycles, MSB first; on the cycle with counter=0 out SHALL load the final P and out_ready SHALL go high, state to DONE.
REQ-017 Latency: out_ready SHALL be visible NLEN+1 posedges after the capture posedge, independent of operand values.
REQ-018 in_ready changes during RUN SHALL be ignored; the operation completes.
REQ-019 DONE SHALL hold out and out_ready=1 while in_ready=1; in_ready=0 in DONE SHALL clear out_ready next posedge and go to IDLE.
REQ-020 A new operation SHALL start only from IDLE; re-requests need either in_ready low for one cycle or a reset pulse.
REQ-021 in2 = 0 or in1 = 0 SHALL yield out = 0 at normal latency.
REQ-022 Precondition violations (without REQ-029) SHALL give an unspecified out but still assert out_ready at normal latency.

Reset
REQ-023 reset=0 SHALL immediately, without clk, force state IDLE, out_ready=0, out=0, P=0, counter=0.
REQ-024 reset asserted mid-RUN SHALL abort the operation; no partial result appears on out.
REQ-025 After reset deasserts with in_ready already high, capture SHALL occur on the first posedge after release.
REQ-026 Captured operand registers need no reset value beyond P and counter.

Configuration
REQ-027 Macro MODMULT_BOUNDS_CHECK_EN SHALL control operand checking.
REQ-028 Undefined: no check logic, no err port; behaviour per REQ-022.
REQ-029 Defined: output err (1 bit, reset 0) is added; at capture, if N<=0, in1<0, or in1>=N, state SHALL go directly to DONE with out=0, err=1, out_ready high on the next posedge; err clears on leaving DONE; valid captures keep err=0.

Verification (NLEN=8, TAG=2)
REQ-030 in1=5, in2=7, N=11, in_ready held -> out=2, out_ready high exactly 9 posedges after capture.
REQ-031 in1=250, in2=250, N=251 -> out=1; in2=0 same N -> out=0 at the same latency.
REQ-032 Reset low at RUN cycle 4 -> out_ready=0 and out=0 immediately; after release with in_ready high, a full 9-cycle run gives the correct result.
REQ-033 DONE held 5 cycles with in_ready=1 -> out stable, no restart; in_ready low -> out_ready low next posedge; re-raise -> new result after 9 more cycles.
REQ-034 MODMULT_BOUNDS_CHECK_EN defined: in1=12, N=11 -> err=1, out=0, out_ready high 1 posedge after capture; the next valid request gives err=0.

Source files
------------

// File: rtl/modmult_interleaved.sv
// Interleaved (MSB-first shift-and-add) modular multiplier: out = in1*in2 mod N in NLEN+1 cycles.
// Optional operand bounds checking with an err output is enabled by defining MODMULT_BOUNDS_CHECK_EN.
module modmult_interleaved #(
    parameter int NLEN = 1024,
    parameter int TAG  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic signed [NLEN+TAG:0] in1,
    input  logic signed [NLEN+TAG:0] in2,
    input  logic signed [NLEN:0]   N,
    input  logic                   in_ready,
    output logic signed [NLEN+TAG:0] out,
    output logic                   out_ready
`ifdef MODMULT_BOUNDS_CHECK_EN
    ,
    output logic                   err
`endif
);

    localparam int OW = NLEN + TAG + 1;
    localparam int AW = NLEN + 3;
    localparam int CW = $clog2(NLEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   p_q, p_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NLEN:0]   a_q, a_d;
    logic [NLEN:0]   b_q, b_d;
    logic [NLEN:0]   n_q, n_d;
    logic [OW-1:0]   out_q, out_d;
    logic            rdy_q, rdy_d;
    logic            err_q, err_d;

    logic [AW-1:0]   n_ext_s;
    logic [AW-1:0]   two_n_s;
    logic [AW-1:0]   addend_s;
    logic [AW-1:0]   t_s;
    logic [AW-1:0]   p_step_s;
    logic            bad_s;
    logic            unused_s;

    assign unused_s = ^{in2[OW-1:NLEN+1], in1[OW-1:NLEN+1], p_q[AW-1]};

    // One interleaved step: double, conditionally add in1, then fold back below N.
    always_comb begin
        n_ext_s  = {2'b00, n_q};
        two_n_s  = {1'b0, n_q, 1'b0};
        addend_s = b_q[cnt_q] ? {2'b00, a_q} : {AW{1'b0}};
        t_s      = {p_q[AW-2:0], 1'b0} + addend_s;
        if (t_s >= two_n_s) begin
            p_step_s = t_s - two_n_s;
        end else if (t_s >= n_ext_s) begin
            p_step_s = t_s - n_ext_s;
        end else begin
            p_step_s = t_s;
        end
    end

`ifdef MODMULT_BOUNDS_CHECK_EN
    logic signed [OW-1:0] n_sx_s;

    // Operand legality at capture: N must be positive and 0 <= in1 < N.
    always_comb begin
        n_sx_s = {{TAG{N[NLEN]}}, N};
        bad_s  = N[NLEN] || (N == {(NLEN+1){1'b0}}) || in1[OW-1] || (in1 >= n_sx_s);
    end
`else
    assign bad_s = 1'b0;
`endif

    // Next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        out_d   = out_q;
        rdy_d   = rdy_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                rdy_d = 1'b0;
                if (in_ready) begin
                    a_d     = in1[NLEN:0];
                    b_d     = in2[NLEN:0];
                    n_d     = N;
                    p_d     = {AW{1'b0}};
                    cnt_d   = CW'(NLEN);
                    err_d   = 1'b0;
                    state_d = RUN;
                    if (bad_s) begin
                        // Illegal operands skip the run and report straight away.
                        out_d   = {OW{1'b0}};
                        rdy_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                p_d = p_step_s;
                if (cnt_q == {CW{1'b0}}) begin
                    out_d   = OW'(p_step_s);
                    rdy_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                    state_d = RUN;
                end
            end
            DONE: begin
                if (in_ready) begin
                    state_d = DONE;
                end else begin
                    rdy_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                rdy_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Control, accumulator and result registers; reset aborts any run in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            p_q     <= {AW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            out_q   <= {OW{1'b0}};
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end

    // Captured operands are only read during RUN, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
        n_q <= n_d;
    end

    assign out       = out_q;
    assign out_ready = rdy_q;
`ifdef MODMULT_BOUNDS_CHECK_EN
    assign err       = err_q;
`else
    logic unused_err_s;
    assign unused_err_s = err_q ^ bad_s;
`endif

endmodule
